// File: rtl/full_adder_pkg.sv
// Shared definitions for the 1-bit full adder: golden model, checker FSM states
// and the bit layout of the captured failure vector.
package full_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_t;

    // Failure vector layout: {a, b, cin, sum, cout}
    localparam int FV_W    = 5;
    localparam int FV_A    = 4;
    localparam int FV_B    = 3;
    localparam int FV_CIN  = 2;
    localparam int FV_SUM  = 1;
    localparam int FV_COUT = 0;

    function automatic logic fa_sum(input logic a, input logic b, input logic cin);
        return a ^ b ^ cin;
    endfunction

    function automatic logic fa_cout(input logic a, input logic b, input logic cin);
        return (a & b) | (a & cin) | (b & cin);
    endfunction

endpackage

// File: rtl/full_adder_checker_if.sv
// Adder stimulus/response bus: operand triple with its valid strobe, plus the
// adder outputs. The stimulus side drives everything; the checker only observes.
interface full_adder_checker_if;

    logic sample_valid;
    logic a;
    logic b;
    logic cin;
    logic sum;
    logic cout;

    modport master (output sample_valid, a, b, cin, sum, cout);
    modport slave  (input  sample_valid, a, b, cin, sum, cout);

endinterface

// File: rtl/full_adder_chk_delay.sv
// Aligns an accepted operand triple with the adder's delayed response.
// Depth LAT; LAT=0 is a plain pass-through.
module full_adder_chk_delay #(
    parameter int LAT = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in_valid,
    input  logic in_a,
    input  logic in_b,
    input  logic in_cin,
    output logic out_valid,
    output logic out_a,
    output logic out_b,
    output logic out_cin
);

    generate
        if (LAT == 0) begin : g_pass
            logic unused_ctl;
            assign unused_ctl = clk ^ rst ^ clr;
            assign {out_valid, out_a, out_b, out_cin} = {in_valid, in_a, in_b, in_cin};
        end else begin : g_pipe
            logic [3:0] stage_q [LAT];

            always_ff @(posedge clk) begin
                if (rst || clr) begin
                    for (int i = 0; i < LAT; i++) begin
                        stage_q[i] <= '0;
                    end
                end else begin
                    stage_q[0] <= {in_valid, in_a, in_b, in_cin};
                    for (int i = 1; i < LAT; i++) begin
                        stage_q[i] <= stage_q[i-1];
                    end
                end
            end

            assign {out_valid, out_a, out_b, out_cin} = stage_q[LAT-1];
        end
    endgenerate

endmodule

// File: rtl/full_adder_checker.sv
// Response checker for a 1-bit full adder: compares each accepted operand triple
// against the adder output LAT cycles later, counts results, captures first miss.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | after reset, samples ignored
//   ST_RUN   | samples accepted and entered into the delay line
//   ST_DRAIN | LAT cycles so in-flight samples are still compared
//   ST_DONE  | results stable, samples ignored, start re-arms
module full_adder_checker
    import full_adder_pkg::*;
#(
    parameter int LAT   = 0,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    full_adder_checker_if.slave  bus,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt,
    output logic [CNT_W-1:0]     first_fail_idx,
    output logic [FV_W-1:0]      first_fail_vec
);

    localparam logic [2:0]       DRAIN_LOAD = (LAT == 0) ? 3'd0 : 3'(LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    chk_state_t       state_q, state_d;
    logic [2:0]       drain_q, drain_d;
    logic             accept;
    logic             dl_valid, dl_a, dl_b, dl_cin;
    logic             sum_bit, cout_bit;
    logic             cmp_pass;
    logic [CNT_W:0]   idx_sum;
    logic [CNT_W-1:0] idx_sat;
    logic [FV_W-1:0]  fail_vec;

    // The sample presented alongside start is dropped, as is anything outside RUN.
    assign accept = (state_q == ST_RUN) && bus.sample_valid && !start;

    full_adder_chk_delay #(.LAT(LAT)) u_delay (
        .clk       (clk),
        .rst       (rst),
        .clr       (start),
        .in_valid  (accept),
        .in_a      (bus.a),
        .in_b      (bus.b),
        .in_cin    (bus.cin),
        .out_valid (dl_valid),
        .out_a     (dl_a),
        .out_b     (dl_b),
        .out_cin   (dl_cin)
    );

    // An unknown adder output falls into the else branch and is read as 0.
    always_comb begin
        sum_bit  = 1'b0;
        cout_bit = 1'b0;
        if (bus.sum)  sum_bit  = 1'b1;
        if (bus.cout) cout_bit = 1'b1;
    end

    assign cmp_pass = (sum_bit == fa_sum(dl_a, dl_b, dl_cin)) &&
                      (cout_bit == fa_cout(dl_a, dl_b, dl_cin));

    assign idx_sum = {1'b0, pass_cnt} + {1'b0, fail_cnt};
    assign idx_sat = idx_sum[CNT_W] ? CNT_MAX : idx_sum[CNT_W-1:0];

    always_comb begin
        fail_vec          = '0;
        fail_vec[FV_A]    = dl_a;
        fail_vec[FV_B]    = dl_b;
        fail_vec[FV_CIN]  = dl_cin;
        fail_vec[FV_SUM]  = sum_bit;
        fail_vec[FV_COUT] = cout_bit;
    end

    always_comb begin
        state_d = state_q;
        drain_d = drain_q;
        if (start) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (stop) begin
                        if (LAT == 0) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_DRAIN;
                            drain_d = DRAIN_LOAD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == 3'd0) state_d = ST_DONE;
                    else                 drain_d = drain_q - 3'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            drain_q <= 3'd0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || start) begin
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            first_fail_idx <= '0;
            first_fail_vec <= '0;
            error          <= 1'b0;
        end else if (dl_valid) begin
            if (cmp_pass) begin
                if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + CNT_ONE;
            end else begin
                if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
                if (!error) begin
                    first_fail_idx <= idx_sat;
                    first_fail_vec <= fail_vec;
                    error          <= 1'b1;
                end
            end
        end
    end

    assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_full_adder_checker.sv
// Bench for full_adder_checker: four instances (LAT 0/2/3, and a 3-bit counter
// variant) share one stimulus stream; each has its own adder model and scoreboard.
module tb_full_adder_checker;
    import full_adder_pkg::*;

    localparam int N_DUT = 4;

    typedef struct {
        bit         clr;
        int         due;
        bit         pass;
        logic [4:0] vec;
    } sb_t;

    logic clk = 1'b0;
    logic rst, start, stop, sample_valid, a, b, cin, fault;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   in_run = 1'b0;
    sb_t  sb_q [N_DUT][$];

    always #5 clk = ~clk;

    function automatic int lat_of(input int g);
        return (g == 1) ? 2 : (g == 2) ? 3 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected outcomes are queued when a sample is accepted; start/reset queue a clear.
    always @(posedge clk) begin
        logic s_sum;
        if (rst || start) begin
            for (int g = 0; g < N_DUT; g++) begin
                sb_q[g].delete();
                sb_q[g].push_back('{clr: 1'b1, due: cyc + 1, pass: 1'b0, vec: 5'd0});
            end
            in_run = !rst;
        end else begin
            if (in_run && sample_valid) begin
                for (int g = 0; g < N_DUT; g++) begin
                    s_sum = fa_sum(a, b, cin) & ~(fault & (g == 0));
                    sb_q[g].push_back('{clr: 1'b0, due: cyc + lat_of(g) + 1,
                                        pass: (s_sum == fa_sum(a, b, cin)),
                                        vec: {a, b, cin, s_sum, fa_cout(a, b, cin)}});
                end
            end
            if (stop) in_run = 1'b0;
        end
        cyc++;
    end

    for (genvar g = 0; g < N_DUT; g++) begin : g_dut
        localparam int L   = (g == 1) ? 2 : (g == 2) ? 3 : 0;
        localparam int W   = (g == 3) ? 3 : 16;
        localparam int OI  = (L == 0) ? 0 : L - 1;
        localparam bit FLT = (g == 0);

        full_adder_checker_if bus_if ();
        logic         busy_w, done_w, err_w;
        logic [W-1:0] pass_w, fail_w, idx_w;
        logic [4:0]   vec_w;
        logic [1:0]   live_res;
        logic [1:0]   pipe [L+1];
        logic [1:0]   out_res;
        int           m_pass = 0;
        int           m_fail = 0;
        int           m_idx  = 0;
        bit           m_err  = 1'b0;
        logic [4:0]   m_vec  = 5'd0;

        // Adder under test: optionally faulty sum, behind L pipeline registers.
        assign live_res = {fa_sum(a, b, cin) & ~(fault & FLT), fa_cout(a, b, cin)};
        always @(posedge clk) begin
            pipe[0] <= live_res;
            for (int i = 1; i <= L; i++) pipe[i] <= pipe[i-1];
        end
        assign out_res = (L == 0) ? live_res : pipe[OI];

        assign bus_if.sample_valid = sample_valid;
        assign bus_if.a            = a;
        assign bus_if.b            = b;
        assign bus_if.cin          = cin;
        assign bus_if.sum          = out_res[1];
        assign bus_if.cout         = out_res[0];

        full_adder_checker #(.LAT(L), .CNT_W(W)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .start          (start),
            .stop           (stop),
            .bus            (bus_if),
            .busy           (busy_w),
            .done           (done_w),
            .error          (err_w),
            .pass_cnt       (pass_w),
            .fail_cnt       (fail_w),
            .first_fail_idx (idx_w),
            .first_fail_vec (vec_w)
        );

        always @(negedge clk) begin
            sb_t e;
            int  mx;
            mx = (1 << W) - 1;
            if (cyc > 0) begin
                while (sb_q[g].size() > 0 && sb_q[g][0].due <= cyc) begin
                    e = sb_q[g].pop_front();
                    if (e.clr) begin
                        m_pass = 0; m_fail = 0; m_idx = 0; m_err = 1'b0; m_vec = 5'd0;
                    end else if (e.pass) begin
                        if (m_pass < mx) m_pass++;
                    end else begin
                        if (!m_err) begin
                            m_idx = (m_pass + m_fail > mx) ? mx : m_pass + m_fail;
                            m_vec = e.vec;
                            m_err = 1'b1;
                        end
                        if (m_fail < mx) m_fail++;
                    end
                end
                chk($sformatf("d%0d_sb_pass", g), 32'(pass_w), m_pass);
                chk($sformatf("d%0d_sb_fail", g), 32'(fail_w), m_fail);
                chk($sformatf("d%0d_sb_error", g), 32'(err_w), 32'(m_err));
                chk($sformatf("d%0d_sb_idx", g), 32'(idx_w), m_idx);
                chk($sformatf("d%0d_sb_vec", g), 32'(vec_w), 32'(m_vec));
            end
        end
    end

    task automatic step(input bit v, input logic [2:0] abc, input bit st, input bit sp);
        sample_valid = v;
        {a, b, cin}  = abc;
        start        = st;
        stop         = sp;
        @(posedge clk); #1;
        sample_valid = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "bench did not finish in time");
    end

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; sample_valid = 1'b0;
        a = 1'b0; b = 1'b0; cin = 1'b0; fault = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_busy", 32'(g_dut[0].busy_w), 0);
        chk("rst_done", 32'(g_dut[0].done_w), 0);
        chk("rst_vec",  32'(g_dut[2].vec_w), 0);

        // LAT=0, correct adder
        step(0, 3'b000, 1, 0);
        step(1, 3'b001, 0, 0);
        step(1, 3'b101, 0, 0);
        step(1, 3'b110, 0, 0);
        chk("t1_busy_pre", 32'(g_dut[0].busy_w), 1);
        chk("t1_done_pre", 32'(g_dut[0].done_w), 0);
        step(0, 3'b000, 0, 1);
        chk("t1_done", 32'(g_dut[0].done_w), 1);
        chk("t1_busy", 32'(g_dut[0].busy_w), 0);
        chk("t1_pass", 32'(g_dut[0].pass_w), 3);
        chk("t1_fail", 32'(g_dut[0].fail_w), 0);
        chk("t1_err",  32'(g_dut[0].err_w), 0);
        idle(4);

        // All 8 triples back to back, stop with the last one
        step(0, 3'b000, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 3'(i), 0, (i == 7));
        chk("t2_l2_busy_s1", 32'(g_dut[1].busy_w), 1);
        chk("t2_l2_done_s1", 32'(g_dut[1].done_w), 0);
        idle(1);
        chk("t2_l2_done_s2", 32'(g_dut[1].done_w), 0);
        idle(1);
        chk("t2_l2_done_s3", 32'(g_dut[1].done_w), 1);
        chk("t2_l2_pass",    32'(g_dut[1].pass_w), 8);
        chk("t2_l3_done_s3", 32'(g_dut[2].done_w), 0);
        idle(1);
        chk("t2_l3_done_s4", 32'(g_dut[2].done_w), 1);
        chk("t2_l3_pass",    32'(g_dut[2].pass_w), 8);
        chk("t2_l0_pass",    32'(g_dut[0].pass_w), 8);
        chk("t2_w3_pass",    32'(g_dut[3].pass_w), 7);
        idle(2);

        // LAT=0, adder sum stuck at 0
        fault = 1'b1;
        step(0, 3'b000, 1, 0);
        step(1, 3'b001, 0, 0);
        step(1, 3'b101, 0, 0);
        step(1, 3'b111, 0, 1);
        chk("t3_done", 32'(g_dut[0].done_w), 1);
        chk("t3_fail", 32'(g_dut[0].fail_w), 2);
        chk("t3_pass", 32'(g_dut[0].pass_w), 1);
        chk("t3_idx",  32'(g_dut[0].idx_w), 0);
        chk("t3_vec",  32'(g_dut[0].vec_w), 32'(5'b00100));
        chk("t3_err",  32'(g_dut[0].err_w), 1);
        fault = 1'b0;
        idle(4);

        // Samples in DONE are ignored; start with a sample drops it and clears all
        step(1, 3'b111, 0, 0);
        step(1, 3'b011, 0, 0);
        chk("t4_done_pass", 32'(g_dut[0].pass_w), 1);
        chk("t4_done_fail", 32'(g_dut[0].fail_w), 2);
        step(1, 3'b111, 1, 0);
        chk("t4_rs_pass", 32'(g_dut[0].pass_w), 0);
        chk("t4_rs_fail", 32'(g_dut[0].fail_w), 0);
        chk("t4_rs_err",  32'(g_dut[0].err_w), 0);
        chk("t4_rs_vec",  32'(g_dut[0].vec_w), 0);
        chk("t4_rs_busy", 32'(g_dut[0].busy_w), 1);
        chk("t4_rs_done", 32'(g_dut[0].done_w), 0);
        idle(1);
        chk("t4_rs_pass2", 32'(g_dut[0].pass_w), 0);
        step(1, 3'b011, 0, 0);
        step(0, 3'b000, 0, 1);
        chk("t4_done2", 32'(g_dut[0].done_w), 1);
        chk("t4_pass2", 32'(g_dut[0].pass_w), 1);
        idle(3);
        step(0, 3'b000, 1, 1);
        chk("t4_ss_busy", 32'(g_dut[0].busy_w), 1);
        chk("t4_ss_done", 32'(g_dut[0].done_w), 0);
        step(1, 3'b100, 0, 0);
        chk("t4_ss_busy2", 32'(g_dut[0].busy_w), 1);
        chk("t4_ss_pass",  32'(g_dut[0].pass_w), 1);
        step(0, 3'b000, 0, 1);
        idle(4);

        // Reset mid-RUN with samples in flight
        step(0, 3'b000, 1, 0);
        step(1, 3'b011, 0, 0);
        step(1, 3'b110, 0, 0);
        step(1, 3'b000, 0, 0);
        chk("t5_l0_pre",  32'(g_dut[0].pass_w), 3);
        chk("t5_l3_pre",  32'(g_dut[2].pass_w), 0);
        rst = 1'b1; sample_valid = 1'b1; {a, b, cin} = 3'b111;
        @(posedge clk); #1;
        rst = 1'b0; sample_valid = 1'b0;
        chk("t5_l0_pass", 32'(g_dut[0].pass_w), 0);
        chk("t5_l0_busy", 32'(g_dut[0].busy_w), 0);
        chk("t5_l3_busy", 32'(g_dut[2].busy_w), 0);
        chk("t5_l3_done", 32'(g_dut[2].done_w), 0);
        chk("t5_l2_busy", 32'(g_dut[1].busy_w), 0);
        idle(5);
        chk("t5_l3_late", 32'(g_dut[2].pass_w), 0);
        chk("t5_l2_late", 32'(g_dut[1].pass_w), 0);
        step(1, 3'b111, 0, 0);
        step(1, 3'b010, 0, 0);
        idle(4);
        chk("t5_idle_l0", 32'(g_dut[0].pass_w), 0);
        chk("t5_idle_l3", 32'(g_dut[2].pass_w), 0);
        chk("t5_idle_busy", 32'(g_dut[0].busy_w), 0);

        // 3-bit counters saturate
        step(0, 3'b000, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 3'(i % 8), 0, 0);
        step(0, 3'b000, 0, 1);
        idle(2);
        chk("t6_w3_pass", 32'(g_dut[3].pass_w), 7);
        chk("t6_w3_fail", 32'(g_dut[3].fail_w), 0);
        chk("t6_l0_pass", 32'(g_dut[0].pass_w), 10);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
